// File: rtl/memory_stage_pkg.sv
// Shared types and encodings for the MEM stage: FSM states, address modes,
// result-source selects and a byte sign-extension helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic ADDR_WORD = 1'b0;
    localparam logic ADDR_BYTE = 1'b1;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port: request/ready for the command, rvalid for load data.
// The stage is the master; the memory model or controller is the slave.
interface memory_stage_if #(
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering for stores and lane select + sign-extension for loads.
// Purely combinational; word mode passes data straight through.
module load_store_align
    import mem_pkg::*;
(
    input  logic        i_addr_mode,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_store_dat,
    input  logic [31:0] i_load_dat,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_ext
);

    always_comb begin
        o_wdata    = i_store_dat;
        o_wstrb    = 4'hF;
        o_load_ext = i_load_dat;
        if (i_addr_mode == ADDR_BYTE) begin
            // Byte stores replicate the byte on every lane; the strobe picks the target.
            o_wdata = {4{i_store_dat[7:0]}};
            o_wstrb = 4'b0001 << i_byte_off;
            case (i_byte_off)
                2'd0:    o_load_ext = sext8(i_load_dat[7:0]);
                2'd1:    o_load_ext = sext8(i_load_dat[15:8]);
                2'd2:    o_load_ext = sext8(i_load_dat[23:16]);
                default: o_load_ext = sext8(i_load_dat[31:24]);
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: one data-memory transaction per load/store, stalls upstream while
// it is outstanding, and holds the MEM/WB register (bubbles while stalled).
module memory_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [1:0]            ResultSrcM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic                  AddrModeM,

    memory_stage_if.master        mem,

    output logic                  StallM,

    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] WAIT = ST_WAIT;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic                  w_access;
    logic                  w_store;
    logic                  w_req;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_load_ext;

    // A simultaneous read and write request is treated as a load.
    assign w_access = MemReadM | MemWriteM;
    assign w_store  = MemWriteM & ~MemReadM;

    load_store_align u_align (
        .i_addr_mode (AddrModeM),
        .i_byte_off  (ALUResultM[1:0]),
        .i_store_dat (WriteDataM),
        .i_load_dat  (mem.mem_rdata),
        .o_wdata     (w_wdata),
        .o_wstrb     (w_wstrb),
        .o_load_ext  (w_load_ext)
    );

    always_comb begin
        w_req      = 1'b0;
        w_complete = 1'b0;
        w_next     = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_req = 1'b1;
                    if (mem.mem_ready) begin
                        w_complete = w_store;
                        w_next     = w_store ? IDLE : WAIT;
                    end else begin
                        w_next = REQ;
                    end
                end
            end
            REQ: begin
                w_req = 1'b1;
                if (mem.mem_ready) begin
                    w_complete = w_store;
                    w_next     = w_store ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    w_complete = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Control outputs are forced low while reset is asserted, whatever the inputs.
    assign mem.mem_req   = rst_n & w_req;
    assign mem.mem_we    = rst_n & w_req & w_store;
    assign mem.mem_wstrb = (rst_n & w_req & w_store) ? w_wstrb : 4'h0;
    assign mem.mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign mem.mem_wdata = w_wdata;

    assign StallM = rst_n & w_access & ~w_complete;

    always_ff @(posedge clk) begin
        if (!rst_n || StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= MemReadM ? w_load_ext : '0;
            PCPlus4W   <= PCPlus4M;
        end
    end

endmodule
